// File: rtl/booth_mul_seq_if.sv
// Handshake and result bundle between the CPU control unit and the Booth multiplier.
// The master drives the operands and start; the slave returns busy, done and the product.
interface booth_mul_seq_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed 32x32->64 radix-2 Booth multiplier built around one 32-bit ripple adder.
// One partial-product step per clock over 32 steps; product lands in the HI/LO register pair.
module add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[32];
endmodule

module booth_mul_seq (
    input  logic          clock,
    input  logic          clear,
    booth_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic [31:0] m_q;
    logic [32:0] a_q;
    logic [31:0] q_q;
    logic        q1_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        sub;
    logic        add_en;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [32:0] a_sel;
    logic [32:0] a_d;
    logic [31:0] q_d;
    logic        q1_d;

    assign sub    = q_q[0] & ~q1_q;
    assign add_en = q_q[0] ^ q1_q;
    assign add_b  = sub ? ~m_q : m_q;

    add u_add (
        .a    (a_q[31:0]),
        .b    (add_b),
        .cin  (sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Bit 32 extends the 32-bit adder result to the 33-bit accumulator so -2^31 stays exact.
    assign a_sel = add_en ? {a_q[32] ^ add_b[31] ^ add_cout, add_sum} : a_q;
    assign {a_d, q_d, q1_d} = {a_sel[32], a_sel, q_q};

    // NOTE: all state and outputs live in one clocked block with non-blocking
    // assignments, so every register sees pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q     <= bus.multiplicand;
                        q_q     <= bus.multiplier;
                        a_q     <= '0;
                        q1_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    hi_q    <= a_q[31:0];
                    lo_q    <= q_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
